elevator_call_scheduler: RTL
============================

// Module: elevator_call_scheduler
// PURPOSE
//  Request side of the elevator controller: latches floor call buttons into a pending set, picks the next target floor by SCAN order and drives it to the car FSM.
//  The car FSM moves until current_floor == target_floor and reports idle.
//  This block then clears the served call and times the door-open interval.
//  Sits between the ui_in call buttons and the car state machine; its target_floor feeds the car's requested_floor input.
// PARAMETERS
//  NUM_FLOORS       10        number of floors/call buttons (2..16)
//  FLOOR_W          4         floor index width
//  DOOR_CYCLES      10000000  clk cycles door_open stays high per stop
//  DEBOUNCE_CYCLES  100000    stable-high cycles to accept a press (REQ_DEBOUNCE_EN only)
// PORTS
//  clk            in   1           clock, all state on posedge
//  rst_n          in   1           asynchronous, active-low reset
//  call_btn       in   NUM_FLOORS  call buttons, bit i = floor i, active high
//  current_floor  in   FLOOR_W     car position from the car FSM
//  car_idle       in   1           car FSM is in IDLE (not moving)
//  target_floor   out  FLOOR_W     floor requested of the car; held between dispatches
//  target_valid   out  1           high while a dispatch is outstanding
//  door_open      out  1           high during the door interval
//  dir_up         out  1           current SCAN direction (1 = up)
//  pending        out  NUM_FLOORS  latched, unserved calls
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, pending=0, target_floor=0, target_valid=0, door_open=0, dir_up=1, door timer=0.
//  Call latch:
//   - call_btn[i]=1 at edge N sets pending[i] at N+1. Set is sticky until served.
//   - A press of floor current_floor during DOOR is not latched; it restarts the door timer.
//   - Same-cycle set and clear of one bit: the clear wins only in the DOOR-entry cycle; otherwise set wins.
//  FSM states: IDLE, SELECT, DISPATCH, DOOR.
//   - IDLE: target_valid=0. If pending!=0, go to SELECT next cycle.
//   - SELECT (1 cycle), when dir_up=1: target = lowest pending floor >= current_floor.
//     If there is none: target = highest pending floor < current_floor, and dir_up<=0.
//   - SELECT, when dir_up=0: the mirror rule (highest pending floor <= current_floor; otherwise lowest > current_floor, and dir_up<=1).
//   - SELECT always goes to DISPATCH.
//   - DISPATCH: target_valid=1.
//     - If car_idle && current_floor==target_floor: go to DOOR.
//     - Else, if a pending floor lies strictly between current_floor and target_floor in the direction of travel: go to SELECT (retarget).
//   - DOOR: target_valid=0, door_open=1, pending[target_floor] cleared on entry, timer loaded with DOOR_CYCLES-1.
//     The timer decrements each cycle; at 0, go to IDLE and door_open falls the following cycle.
//     door_open is high for exactly DOOR_CYCLES cycles absent restarts.
//  Latency: press at edge N with car idle elsewhere gives pending at N+1, SELECT at N+2, target_valid=1 and target_floor valid at N+3.
//  A call at the car's own floor while idle reaches DOOR at N+4.
//  current_floor >= NUM_FLOORS: no floor qualifies in SELECT.
//   - target holds its previous value; pending is untouched.
//   - go to DISPATCH, then re-SELECT each cycle until current_floor is legal.
//  Floor comparisons are unsigned, FLOOR_W bits wide. The timer is wide enough for DOOR_CYCLES.
// CONFIGURATION
//  REQ_DEBOUNCE_EN defined:
//   - each call_btn bit passes a 2-FF synchronizer plus a per-button counter.
//   - pending[i] sets only after DEBOUNCE_CYCLES consecutive synchronized-high samples.
//   - press-to-pending latency = 2+DEBOUNCE_CYCLES cycles.
//   - one set per press; re-arms after the input goes low.
//  REQ_DEBOUNCE_EN undefined: raw call_btn is used directly, with 1-cycle latency as above.
// TESTING (DOOR_CYCLES=4, DEBOUNCE_CYCLES=3; a car model steps current_floor ±1 every 3 cycles toward target_floor)
//  1 Reset: assert rst_n=0 mid-DISPATCH -> all outputs at reset values immediately; dir_up=1, pending=0.
//  2 Car at 0, pulse call_btn[3] -> pending=0x008 next edge; target_floor=3, target_valid=1 at +3.
//    On arrival: door_open high 4 cycles, pending=0.
//  3 Car at 5 with dir_up=1, pending {2,7} -> target 7 served first; then target 2 with dir_up=0.
//  4 Dispatching 2->8 at floor 3, press 5 -> target_floor=5 within 2 cycles.
//    Press 1 instead -> target stays 8.
//  5 In DOOR at floor 4, press call_btn[4] -> pending[4] stays 0 and door_open lasts 4 cycles from the press.
//  6 REQ_DEBOUNCE_EN: 2-cycle glitch on call_btn[6] -> pending unchanged.
//    Hold call_btn[6] for 6 cycles -> pending[6]=1 exactly once.

Source files
------------

// File: rtl/elevator_call_scheduler.sv
// elevator_call_scheduler
//   Request side of the elevator controller. Latches call buttons into a
//   pending set, picks the next target floor in SCAN order, hands it to the
//   car FSM, clears the served call on arrival and times the door interval.
//   Optional feature macro: REQ_DEBOUNCE_EN (2-FF synchronizer plus
//   per-button debounce counter in front of the pending set).
module elevator_call_scheduler #(
    parameter int NUM_FLOORS      = 10,
    parameter int FLOOR_W         = 4,
    parameter int DOOR_CYCLES     = 10000000,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  car_idle,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  target_valid,
    output logic                  door_open,
    output logic                  dir_up,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int TIMER_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] DOOR_LOAD = TIMER_W'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SELECT   = 2'd1,
        ST_DISPATCH = 2'd2,
        ST_DOOR     = 2'd3
    } state_t;

    state_t                state_r, state_next_s;
    logic [NUM_FLOORS-1:0] pending_r, pending_next_s;
    logic [FLOOR_W-1:0]    target_floor_r;
    logic                  target_valid_r, door_open_r, dir_up_r;
    logic [TIMER_W-1:0]    timer_r, timer_next_s;

    logic [NUM_FLOORS-1:0] set_mask_s, own_mask_s, clear_mask_s;
    logic                  cur_legal_s, arrive_s, between_s, door_entry_s, door_press_s;
    logic                  lo_ge_found_s, lo_gt_found_s, hi_le_found_s, hi_lt_found_s;
    logic [FLOOR_W-1:0]    lo_ge_s, lo_gt_s, hi_le_s, hi_lt_s;
    logic                  sel_found_s, sel_dir_s;
    logic [FLOOR_W-1:0]    sel_target_s;

`ifdef REQ_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_FLOORS-1:0] sync1_r, sync2_r, fired_r, set_pulse_r;
    logic [CNT_W-1:0]      cnt_r [NUM_FLOORS];

    // Synchronize each button and emit one set pulse per stable press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r     <= {NUM_FLOORS{1'b0}};
            sync2_r     <= {NUM_FLOORS{1'b0}};
            fired_r     <= {NUM_FLOORS{1'b0}};
            set_pulse_r <= {NUM_FLOORS{1'b0}};
            for (int i = 0; i < NUM_FLOORS; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            sync1_r <= call_btn;
            sync2_r <= sync1_r;
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (!sync2_r[i]) begin
                    cnt_r[i]       <= {CNT_W{1'b0}};
                    fired_r[i]     <= 1'b0;
                    set_pulse_r[i] <= 1'b0;
                end else if (fired_r[i]) begin
                    set_pulse_r[i] <= 1'b0;
                end else if (cnt_r[i] == CNT_LAST) begin
                    cnt_r[i]       <= {CNT_W{1'b0}};
                    fired_r[i]     <= 1'b1;
                    set_pulse_r[i] <= 1'b1;
                end else begin
                    cnt_r[i]       <= cnt_r[i] + CNT_W'(1'b1);
                    set_pulse_r[i] <= 1'b0;
                end
            end
        end
    end

    assign set_mask_s = set_pulse_r;
`else
    assign set_mask_s = call_btn;
`endif

    assign cur_legal_s  = ({1'b0, current_floor} < (FLOOR_W+1)'(NUM_FLOORS));
    assign arrive_s     = car_idle && (current_floor == target_floor_r);
    assign door_entry_s = (state_r == ST_DISPATCH) && arrive_s;
    assign door_press_s = (state_r == ST_DOOR) && (|(set_mask_s & own_mask_s));

    // Scan the pending set for the nearest call on each side of the car and for calls en route.
    always_comb begin
        lo_ge_found_s = 1'b0; lo_ge_s = {FLOOR_W{1'b0}};
        lo_gt_found_s = 1'b0; lo_gt_s = {FLOOR_W{1'b0}};
        hi_le_found_s = 1'b0; hi_le_s = {FLOOR_W{1'b0}};
        hi_lt_found_s = 1'b0; hi_lt_s = {FLOOR_W{1'b0}};
        between_s     = 1'b0;
        own_mask_s    = {NUM_FLOORS{1'b0}};
        clear_mask_s  = {NUM_FLOORS{1'b0}};
        // Descending walk: the last hit is the lowest qualifying floor.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            lo_ge_s       = (pending_r[i] && (FLOOR_W'(i) >= current_floor)) ? FLOOR_W'(i) : lo_ge_s;
            lo_ge_found_s = lo_ge_found_s | (pending_r[i] && (FLOOR_W'(i) >= current_floor));
            lo_gt_s       = (pending_r[i] && (FLOOR_W'(i) >  current_floor)) ? FLOOR_W'(i) : lo_gt_s;
            lo_gt_found_s = lo_gt_found_s | (pending_r[i] && (FLOOR_W'(i) >  current_floor));
        end
        // Ascending walk: the last hit is the highest qualifying floor.
        for (int i = 0; i < NUM_FLOORS; i++) begin
            hi_le_s       = (pending_r[i] && (FLOOR_W'(i) <= current_floor)) ? FLOOR_W'(i) : hi_le_s;
            hi_le_found_s = hi_le_found_s | (pending_r[i] && (FLOOR_W'(i) <= current_floor));
            hi_lt_s       = (pending_r[i] && (FLOOR_W'(i) <  current_floor)) ? FLOOR_W'(i) : hi_lt_s;
            hi_lt_found_s = hi_lt_found_s | (pending_r[i] && (FLOOR_W'(i) <  current_floor));
            between_s     = between_s | (pending_r[i] &&
                            (((FLOOR_W'(i) > current_floor) && (FLOOR_W'(i) < target_floor_r)) ||
                             ((FLOOR_W'(i) < current_floor) && (FLOOR_W'(i) > target_floor_r))));
            own_mask_s[i]   = (current_floor  == FLOOR_W'(i));
            clear_mask_s[i] = (target_floor_r == FLOOR_W'(i));
        end
    end

    // SCAN choice: keep going in the current direction, otherwise reverse.
    always_comb begin
        sel_found_s  = 1'b0;
        sel_target_s = target_floor_r;
        sel_dir_s    = dir_up_r;
        if (!cur_legal_s) begin
            sel_found_s = 1'b0;
        end else if (dir_up_r) begin
            if (lo_ge_found_s) begin
                sel_found_s = 1'b1; sel_target_s = lo_ge_s; sel_dir_s = 1'b1;
            end else if (hi_lt_found_s) begin
                sel_found_s = 1'b1; sel_target_s = hi_lt_s; sel_dir_s = 1'b0;
            end else begin
                sel_found_s = 1'b0;
            end
        end else begin
            if (hi_le_found_s) begin
                sel_found_s = 1'b1; sel_target_s = hi_le_s; sel_dir_s = 1'b0;
            end else if (lo_gt_found_s) begin
                sel_found_s = 1'b1; sel_target_s = lo_gt_s; sel_dir_s = 1'b1;
            end else begin
                sel_found_s = 1'b0;
            end
        end
    end

    // Next state and door timer.
    always_comb begin
        state_next_s = state_r;
        timer_next_s = timer_r;
        case (state_r)
            ST_IDLE: begin
                if (|pending_r) state_next_s = ST_SELECT;
                else            state_next_s = ST_IDLE;
            end
            ST_SELECT: begin
                state_next_s = ST_DISPATCH;
            end
            ST_DISPATCH: begin
                if (arrive_s) begin
                    state_next_s = ST_DOOR;
                    timer_next_s = DOOR_LOAD;
                end else if (!cur_legal_s || between_s) begin
                    state_next_s = ST_SELECT;
                end else begin
                    state_next_s = ST_DISPATCH;
                end
            end
            ST_DOOR: begin
                if (door_press_s) begin
                    state_next_s = ST_DOOR;
                    timer_next_s = DOOR_LOAD;
                end else if (timer_r == {TIMER_W{1'b0}}) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DOOR;
                    timer_next_s = timer_r - TIMER_W'(1'b1);
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Pending set: sticky sets, own-floor presses swallowed during DOOR, clear wins on DOOR entry.
    always_comb begin
        pending_next_s = pending_r;
        if (state_r == ST_DOOR) pending_next_s = pending_r | (set_mask_s & ~own_mask_s);
        else                    pending_next_s = pending_r | set_mask_s;
        if (door_entry_s) pending_next_s = pending_next_s & ~clear_mask_s;
        else              pending_next_s = pending_next_s;
    end

    // State, timer, pending set and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            timer_r        <= {TIMER_W{1'b0}};
            pending_r      <= {NUM_FLOORS{1'b0}};
            target_valid_r <= 1'b0;
            door_open_r    <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            timer_r        <= timer_next_s;
            pending_r      <= pending_next_s;
            target_valid_r <= (state_next_s == ST_DISPATCH);
            door_open_r    <= (state_next_s == ST_DOOR);
        end
    end

    // Target and direction only change when SELECT finds a qualifying floor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_floor_r <= {FLOOR_W{1'b0}};
            dir_up_r       <= 1'b1;
        end else if ((state_r == ST_SELECT) && sel_found_s) begin
            target_floor_r <= sel_target_s;
            dir_up_r       <= sel_dir_s;
        end
    end

    assign target_floor = target_floor_r;
    assign target_valid = target_valid_r;
    assign door_open    = door_open_r;
    assign dir_up       = dir_up_r;
    assign pending      = pending_r;

endmodule
